// File: rtl/pergate_gatefn_tdm_pkg.sv
// rtl/pergate_gatefn_tdm_pkg.sv - shared gate-function definitions: field, op codes, FSM states
// Field is GF(p) with the Mersenne prime p = 2^31-1, so reduction is a fold-and-add.
package pergate_gatefn_tdm_pkg;

  localparam int F_NBITS     = 31;
  localparam int GATEFN_BITS = 2;

  typedef logic [F_NBITS-1:0] felem_t;

  localparam felem_t P = 31'h7FFF_FFFF;

  localparam logic [GATEFN_BITS-1:0] GATEFN_ADD = 2'd0;
  localparam logic [GATEFN_BITS-1:0] GATEFN_MUL = 2'd1;
  localparam logic [GATEFN_BITS-1:0] GATEFN_SUB = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_COLLECT = 2'd3;

  function automatic logic op_legal(input logic [GATEFN_BITS-1:0] op);
    return (op == GATEFN_ADD) || (op == GATEFN_MUL) || (op == GATEFN_SUB);
  endfunction

  function automatic felem_t fadd(input felem_t a, input felem_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[F_NBITS-1:0];
  endfunction

  // Operands are already reduced, so a+p-b fits in F_NBITS bits whenever a<b.
  function automatic felem_t fsub(input felem_t a, input felem_t b);
    if (a >= b) return a - b;
    return a + (P - b);
  endfunction

  function automatic felem_t fred(input logic [2*F_NBITS-1:0] x);
    logic [F_NBITS:0] s;
    logic [F_NBITS:0] t;
    s = {1'b0, x[F_NBITS-1:0]} + {1'b0, x[2*F_NBITS-1:F_NBITS]};
    t = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
    if (t >= {1'b0, P}) t = t - {1'b0, P};
    return t[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/gatefn_lane.sv
// rtl/gatefn_lane.sv - one field-arithmetic lane; ADD/SUB take one cycle, MUL two
// ready_pulse marks the cycle out first holds the new result; out holds until the next en.
module gatefn_lane
  import pergate_gatefn_tdm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [GATEFN_BITS-1:0] op,
  input  felem_t                 a,
  input  felem_t                 b,
  output logic                   ready_pulse,
  output felem_t                 out
);

  logic [2*F_NBITS-1:0] prod_q;
  logic                 mul_v_q;
  logic                 done_q;
  felem_t               out_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prod_q  <= '0;
      mul_v_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      mul_v_q <= 1'b0;
      if (mul_v_q) begin
        out_q  <= fred(prod_q);
        done_q <= 1'b1;
      end
      if (en) begin
        case (op)
          GATEFN_MUL: begin
            prod_q  <= {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
            mul_v_q <= 1'b1;
          end
          GATEFN_SUB: begin
            out_q  <= fsub(a, b);
            done_q <= 1'b1;
          end
          default: begin
            out_q  <= fadd(a, b);
            done_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready_pulse = done_q;
  assign out         = out_q;

endmodule

// File: rtl/pergate_gatefn_tdm.sv
// rtl/pergate_gatefn_tdm.sv - nVals gate-function evaluations time-multiplexed over nLanes lanes
// Round r, lane k evaluates index r*nLanes+k; lanes past nVals stay idle in the last round.
module pergate_gatefn_tdm
  import pergate_gatefn_tdm_pkg::*;
#(
  parameter int nVals  = 4,
  parameter int nLanes = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [GATEFN_BITS-1:0] op,
  input  felem_t [nVals-1:0]     in0,
  input  felem_t [nVals-1:0]     in1,
  output logic                   ready,
  output logic                   ready_pulse,
  output logic                   op_err,
  output felem_t [nVals-1:0]     gatefn
);

  localparam int NROUNDS = (nVals + nLanes - 1) / nLanes;
  localparam int RW      = $clog2(NROUNDS + 1);

  logic [1:0]             state_q, state_d;
  logic [RW-1:0]          round_q, round_d;
  logic [nLanes-1:0]      flags_q, flags_d;
  logic [GATEFN_BITS-1:0] op_q, op_d;
  felem_t [nVals-1:0]     a_q, a_d, b_q, b_d;
  felem_t [nVals-1:0]     gatefn_q, gatefn_d;
  logic                   ready_q, ready_d;
  logic                   pulse_q, pulse_d;
  logic                   err_q, err_d;

  logic [nLanes-1:0]      lane_act;
  logic [nLanes-1:0]      lane_en;
  logic [nLanes-1:0]      lane_done;
  felem_t [nLanes-1:0]    lane_a, lane_b, lane_out;

  always_comb begin
    for (int k = 0; k < nLanes; k++) begin
      lane_act[k] = (int'(round_q) * nLanes + k) < nVals;
      lane_a[k]   = '0;
      lane_b[k]   = '0;
      for (int j = 0; j < nVals; j++) begin
        if (j == int'(round_q) * nLanes + k) begin
          lane_a[k] = a_q[j];
          lane_b[k] = b_q[j];
        end
      end
    end
  end

  for (genvar k = 0; k < nLanes; k++) begin : g_lane
    gatefn_lane u_lane (
      .clk        (clk),
      .rstb       (rstb),
      .en         (lane_en[k]),
      .op         (op_q),
      .a          (lane_a[k]),
      .b          (lane_b[k]),
      .ready_pulse(lane_done[k]),
      .out        (lane_out[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    flags_d  = flags_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gatefn_d = gatefn_q;
    ready_d  = ready_q;
    pulse_d  = 1'b0;
    err_d    = err_q;
    lane_en  = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          // An illegal op completes immediately without touching the lanes or results.
          if (op_legal(op)) begin
            op_d    = op;
            a_d     = in0;
            b_d     = in1;
            err_d   = 1'b0;
            ready_d = 1'b0;
            round_d = '0;
            flags_d = '0;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            pulse_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        lane_en = lane_act;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        flags_d = flags_q | (lane_done & lane_act);
        if ((flags_d & lane_act) == lane_act) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        for (int k = 0; k < nLanes; k++) begin
          for (int j = 0; j < nVals; j++) begin
            if (lane_act[k] && (j == int'(round_q) * nLanes + k)) gatefn_d[j] = lane_out[k];
          end
        end
        flags_d = '0;
        round_d = round_q + 1'b1;
        if (round_q == RW'(NROUNDS - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      flags_q  <= '0;
      op_q     <= GATEFN_ADD;
      a_q      <= '0;
      b_q      <= '0;
      gatefn_q <= '0;
      ready_q  <= 1'b1;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      flags_q  <= flags_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gatefn_q <= gatefn_d;
      ready_q  <= ready_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  assign ready       = ready_q;
  assign ready_pulse = pulse_q;
  assign op_err      = err_q;
  assign gatefn      = gatefn_q;

endmodule

// File: tb/tb_pergate_gatefn_tdm.sv
// tb/tb_pergate_gatefn_tdm.sv - table-driven bench for pergate_gatefn_tdm (4/2 and 5/2 configurations)
module tb_pergate_gatefn_tdm;
  import pergate_gatefn_tdm_pkg::*;

  localparam logic [30:0] PP = 31'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic             en4, rdy4, pl4, err4;
  logic [1:0]       op4;
  logic [3:0][30:0] in0_4, in1_4, g4;

  logic             en5, rdy5, pl5, err5;
  logic [1:0]       op5;
  logic [4:0][30:0] in0_5, in1_5, g5;

  pergate_gatefn_tdm #(.nVals(4), .nLanes(2)) dut4 (
    .clk(clk), .rstb(rstb), .en(en4), .op(op4), .in0(in0_4), .in1(in1_4),
    .ready(rdy4), .ready_pulse(pl4), .op_err(err4), .gatefn(g4)
  );

  pergate_gatefn_tdm #(.nVals(5), .nLanes(2)) dut5 (
    .clk(clk), .rstb(rstb), .en(en5), .op(op5), .in0(in0_5), .in1(in1_5),
    .ready(rdy5), .ready_pulse(pl5), .op_err(err5), .gatefn(g5)
  );

  typedef struct {
    logic [1:0]       op;
    logic [3:0][30:0] a;
    logic [3:0][30:0] b;
    logic [3:0][30:0] exp;
    logic             exp_err;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][30:0] mk4(input logic [30:0] x0, x1, x2, x3);
    logic [3:0][30:0] r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
    return r;
  endfunction

  // Issue one request on dut4, scramble inputs after accept, then observe 40 cycles.
  task automatic run4(input logic [1:0] op, input logic [3:0][30:0] a, input logic [3:0][30:0] b,
                      output int npulse, output int lat, output int nissue, output logic rdy_after);
    npulse = 0; lat = -1; nissue = 0;
    @(negedge clk);
    en4 = 1'b1; op4 = op; in0_4 = a; in1_4 = b;
    @(negedge clk);
    en4 = 1'b0; op4 = 2'd3; in0_4 = mk4(31'd77, 31'd77, 31'd77, 31'd77); in1_4 = in0_4;
    rdy_after = rdy4;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (pl4) begin
        npulse++;
        if (lat < 0) lat = c;
      end
      if (|dut4.lane_en) nissue++;
    end
  endtask

  int   np, lt, ni, lane1_r3;
  logic ra;

  initial begin
    vecs[0] = '{op: GATEFN_ADD, a: mk4(1, 2, 3, 4), b: mk4(5, 6, 7, 8),
                exp: mk4(6, 8, 10, 12), exp_err: 1'b0};
    vecs[1] = '{op: GATEFN_MUL, a: mk4(PP - 31'd1, 3, 0, 100000), b: mk4(2, 4, 5, 100000),
                exp: mk4(PP - 31'd2, 12, 0, 31'd1410065412), exp_err: 1'b0};
    vecs[2] = '{op: GATEFN_SUB, a: mk4(5, 3, 0, PP - 31'd1), b: mk4(2, 5, 1, PP - 31'd1),
                exp: mk4(3, PP - 31'd2, PP - 31'd1, 0), exp_err: 1'b0};
    vecs[3] = '{op: GATEFN_ADD, a: mk4(PP - 31'd1, PP - 31'd1, 0, 10), b: mk4(1, PP - 31'd1, 0, 20),
                exp: mk4(0, PP - 31'd2, 0, 30), exp_err: 1'b0};
    vecs[4] = '{op: 2'd3, a: mk4(9, 9, 9, 9), b: mk4(9, 9, 9, 9),
                exp: mk4(0, PP - 31'd2, 0, 30), exp_err: 1'b1};
    vecs[5] = '{op: GATEFN_ADD, a: mk4(1, 1, 1, 1), b: mk4(1, 1, 1, 1),
                exp: mk4(2, 2, 2, 2), exp_err: 1'b0};

    rstb = 1'b0;
    en4 = 1'b0; op4 = '0; in0_4 = '0; in1_4 = '0;
    en5 = 1'b0; op5 = '0; in0_5 = '0; in1_5 = '0;
    repeat (3) @(negedge clk);
    chk("reset ready4", rdy4, 1);
    chk("reset pulse4", pl4, 0);
    chk("reset err4", err4, 0);
    chk("reset gatefn4", g4, 0);
    chk("reset ready5", rdy5, 1);
    chk("reset gatefn5", g5, 0);
    rstb = 1'b1;
    @(negedge clk);
    chk("no pulse after reset release", pl4 | pl5, 0);
    @(negedge clk);
    chk("no pulse 2nd cycle after release", pl4 | pl5, 0);

    for (int v = 0; v < 6; v++) begin
      run4(vecs[v].op, vecs[v].a, vecs[v].b, np, lt, ni, ra);
      chk($sformatf("vec%0d pulse count", v), np, 1);
      chk($sformatf("vec%0d op_err", v), err4, vecs[v].exp_err);
      for (int i = 0; i < 4; i++)
        chk($sformatf("vec%0d gatefn[%0d]", v, i), g4[i], vecs[v].exp[i]);
      if (vecs[v].exp_err) begin
        chk($sformatf("vec%0d pulse latency", v), lt, 1);
        chk($sformatf("vec%0d issue cycles", v), ni, 0);
      end else begin
        chk($sformatf("vec%0d ready after accept", v), ra, 0);
        chk($sformatf("vec%0d rounds", v), ni, 2);
      end
      chk($sformatf("vec%0d ready at end", v), rdy4, 1);
    end

    // en pulsed while in WAIT must be ignored
    @(negedge clk);
    en4 = 1'b1; op4 = GATEFN_ADD; in0_4 = mk4(1, 2, 3, 4); in1_4 = mk4(5, 6, 7, 8);
    @(negedge clk);
    en4 = 1'b0;
    @(negedge clk);
    en4 = 1'b1; op4 = GATEFN_MUL; in0_4 = mk4(9, 9, 9, 9); in1_4 = mk4(3, 3, 3, 3);
    @(negedge clk);
    en4 = 1'b0;
    np = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pl4) np++;
    end
    chk("en-in-wait pulse count", np, 1);
    chk("en-in-wait gatefn", g4, mk4(6, 8, 10, 12));

    // reset asserted during WAIT of the second round
    @(negedge clk);
    en4 = 1'b1; op4 = GATEFN_ADD; in0_4 = mk4(10, 20, 30, 40); in1_4 = mk4(1, 1, 1, 1);
    @(negedge clk);
    en4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset in flight", rdy4, 0);
    rstb = 1'b0;
    #1;
    chk("mid-reset ready", rdy4, 1);
    chk("mid-reset pulse", pl4, 0);
    chk("mid-reset err", err4, 0);
    chk("mid-reset gatefn", g4, 0);
    @(negedge clk);
    rstb = 1'b1;
    np = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pl4) np++;
    end
    chk("post-abort pulse count", np, 0);
    chk("post-abort gatefn held", g4, 0);
    run4(GATEFN_ADD, mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), np, lt, ni, ra);
    chk("post-abort request pulse", np, 1);
    chk("post-abort request gatefn", g4, mk4(6, 8, 10, 12));

    // 5 values over 2 lanes: three rounds, lane 1 idle in the last
    @(negedge clk);
    en5 = 1'b1; op5 = GATEFN_ADD;
    in0_5[0] = 1; in0_5[1] = 2; in0_5[2] = 3; in0_5[3] = 4; in0_5[4] = 5;
    in1_5[0] = 10; in1_5[1] = 20; in1_5[2] = 30; in1_5[3] = 40; in1_5[4] = 50;
    @(negedge clk);
    en5 = 1'b0;
    np = 0; ni = 0; lane1_r3 = 0;
    for (int c = 0; c < 40; c++) begin
      if (pl5) np++;
      if (|dut5.lane_en) ni++;
      if (dut5.lane_en[1] && dut5.round_q == 2) lane1_r3++;
      @(negedge clk);
    end
    chk("nv5 pulse count", np, 1);
    chk("nv5 rounds", ni, 3);
    chk("nv5 lane1 enabled in round 3", lane1_r3, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("nv5 gatefn[%0d]", i), g5[i], 11 * (i + 1));
    chk("nv5 op_err", err5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pergate_gatefn_tdm.md
PERGATE_GATEFN_TDM -- requirements
Module: pergate_gatefn_tdm

Interface
REQ-001 SHALL have parameter nVals, default 4, number of evaluations (V(0)..V(nVals-1)) per request.
REQ-002 SHALL have parameter nLanes, default 2, number of physical field-arithmetic lanes; legal range 1..nVals.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstb  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port en  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port op  input  `GATEFN_BITS  runtime gate function: GATEFN_ADD, GATEFN_MUL or GATEFN_SUB.
REQ-007 SHALL have port in0  input  `F_NBITS x nVals  first operands.
REQ-008 SHALL have port in1  input  `F_NBITS x nVals  second operands.
REQ-009 SHALL have port ready  output  1  high when idle with results valid.
REQ-010 SHALL have port ready_pulse  output  1  one-cycle pulse on ready rising.
REQ-011 SHALL have port op_err  output  1  last request carried an unsupported op code.
REQ-012 SHALL have port gatefn  output  `F_NBITS x nVals  results, mod field prime p.

Function
REQ-013 SHALL compute gatefn[i] = in0[i]+in1[i], in0[i]*in1[i] or in0[i]-in1[i] (mod p) per op, for all i.
REQ-014 SHALL capture op, in0, in1 into internal registers on the cycle en is accepted; inputs may change afterwards.
REQ-015 SHALL time-multiplex nVals evaluations over nLanes lanes in nRounds = ceil(nVals/nLanes) rounds; round r, lane k handles index r*nLanes+k.
REQ-016 SHALL leave lanes with index >= nVals un-enabled in the last partial round; their outputs are not written.
REQ-017 SHALL use FSM states IDLE, ISSUE, WAIT, COLLECT.
REQ-018 IDLE -> ISSUE when en=1; ready falls the following cycle.
REQ-019 ISSUE SHALL assert lane enable for exactly one cycle to all active lanes, then -> WAIT.
REQ-020 WAIT SHALL latch each active lane's done pulse into a sticky flag; -> COLLECT when all active flags are set, regardless of completion order.
REQ-021 COLLECT SHALL write active lane results to gatefn, clear flags, increment round counter; -> ISSUE if rounds remain, else -> IDLE with ready=1 and ready_pulse=1 for one cycle.
REQ-022 en while not IDLE SHALL be ignored (no queueing, no state change).
REQ-023 Unsupported op SHALL set op_err, skip all rounds, go ISSUE-free to IDLE next cycle with ready_pulse, gatefn unchanged; op_err clears on next accepted en with legal op.
REQ-024 gatefn SHALL hold its value between requests and change only in COLLECT.
REQ-025 Outputs SHALL be registered; no combinational path from en/op/in0/in1 to any output.
REQ-026 All results SHALL be fully reduced to [0, p-1].

Reset
REQ-027 On rstb low: state=IDLE, ready=1, ready_pulse=0, op_err=0, gatefn all 0, round counter and lane flags 0, lanes reset.
REQ-028 Reset asserted mid-request SHALL abort it; no ready_pulse produced upon deassertion.
REQ-029 ready_pulse SHALL NOT fire on the first cycle after reset release.

Structure
REQ-030 State enum and op-code constants SHALL live in the shared gatefn definitions package/header alongside GATEFN_BITS.
REQ-031 SHALL use one sub-module gatefn_lane: clk, rstb, en, op, a, b -> ready_pulse, out; wraps the codebase field adder, subtractor and multiplier; variable latency.
REQ-032 Round counter width SHALL be $clog2(nRounds+1).

Verification
REQ-033 nVals=4,nLanes=2, ADD in0={1,2,3,4}, in1={5,6,7,8} -> gatefn={6,8,10,12}, exactly one ready_pulse, two rounds.
REQ-034 MUL in0[0]=p-1, in1[0]=2 -> gatefn[0]=p-2; SUB in0[1]=3, in1[1]=5 -> gatefn[1]=p-2.
REQ-035 nVals=5,nLanes=2 -> 3 rounds; lane 1 never enabled in round 3; gatefn[4] correct.
REQ-036 en pulsed during WAIT with different operands -> ignored; results match first request only.
REQ-037 rstb low during WAIT of round 2 -> all outputs at reset values, ready=1, no ready_pulse; next request completes correctly.
REQ-038 op = illegal code -> op_err=1, ready_pulse one cycle after accept, gatefn unchanged.
